pic_priority_core: RTL and testbench

Interrupt-handling core of the 8259A model, directly downstream of the read/write command logic. It holds IRR, ISR and IMR, resolves priority (fully nested, optionally rotating) and drives the INT request. It also runs the two-pulse INTA vector sequence and executes the EOI/priority commands carried by OCW1–OCW3. The command logic provides decoded write strobes, the data byte and ICW-derived mode bits.

---
 rtl/pic_priority_core.sv | 208 ++++++++++++++++++++
 tb/tb_pic_priority_core.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_priority_core.sv
`timescale 1ns/1ps
// pic_priority_core
// Interrupt-handling core of an 8259A-style controller. Holds IRR, ISR and
// IMR, resolves priority (fully nested, optionally rotating), drives the
// interrupt request and runs the two-pulse INTA vector sequence. It also
// executes the EOI / priority commands carried by OCW1..OCW3.
//
// Optional feature macro: PIC_ROTATE_EN
//   defined   - OCW2 rotate codes and rotate-in-AEOI move the lowest priority
//   undefined - lowest priority fixed at IR7 (IR0 highest), rotate codes only
//               perform their EOI action, set-priority is a no-op
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   ir[7:0]            raw interrupt request lines
//   icw1_wr            re-initialisation strobe
//   init_done          ICW sequence complete; core inactive while low
//   ltim, aeoi         level-trigger mode, automatic EOI mode
//   vec_base[4:0]      vector bits T7..T3
//   ocw1/2/3_wr, wdata command strobes and their data byte
//   inta, a0           interrupt acknowledge strobe, read address select
//   int_req            registered interrupt request to the CPU
//   vec_out, vec_valid vector byte and its one-cycle valid pulse
//   rdata              combinational status read (IMR / ISR / IRR)
module pic_priority_core (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ir,
    input  logic       icw1_wr,
    input  logic       init_done,
    input  logic       ltim,
    input  logic       aeoi,
    input  logic [4:0] vec_base,
    input  logic       ocw1_wr,
    input  logic       ocw2_wr,
    input  logic       ocw3_wr,
    input  logic [7:0] wdata,
    input  logic       inta,
    input  logic       a0,
    output logic       int_req,
    output logic [7:0] vec_out,
    output logic       vec_valid,
    output logic [7:0] rdata
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK1 = 1'b1;

    logic [7:0] irr_reg, isr_reg, imr_reg, ir_q_reg;
    logic [7:0] irr_next, isr_next;
    logic       read_sel_reg;
    logic [0:0] state_reg;
    logic [2:0] level_reg;
    logic       spurious_reg;
    logic [2:0] lowest_prio;

    // Returns {found, rank}: rank 0 is the highest-priority position, i.e.
    // the level just above lowest_prio.
    function automatic logic [3:0] top_rank(input logic [7:0] v, input logic [2:0] lp);
        logic [15:0] dbl;
        logic [7:0]  rot;
        logic [3:0]  res;
        dbl = {v, v} >> ({1'b0, lp} + 4'd1);
        rot = dbl[7:0];
        res = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) res = {1'b1, i[2:0]};
        end
        return res;
    endfunction

    logic [7:0] masked_req;
    logic       req_found, isr_found, pending;
    logic [2:0] req_rank, isr_rank, winner, isr_top;

    assign masked_req             = irr_reg & ~imr_reg;
    assign {req_found, req_rank}  = top_rank(masked_req, lowest_prio);
    assign {isr_found, isr_rank}  = top_rank(isr_reg, lowest_prio);
    assign winner                 = lowest_prio + 3'd1 + req_rank;
    assign isr_top                = lowest_prio + 3'd1 + isr_rank;
    assign pending                = req_found && (!isr_found || (req_rank < isr_rank));

    // Acknowledge sequencing; everything is frozen while init_done is low.
    logic       ack1_go, ack2_go, ocw2_go;
    logic [2:0] ocw2_cmd, ocw2_lvl;
    logic [7:0] ack_mask, eoi_mask, aeoi_mask;

    assign ack1_go  = init_done && inta && (state_reg == ST_IDLE);
    assign ack2_go  = init_done && inta && (state_reg == ST_ACK1);
    assign ocw2_go  = init_done && ocw2_wr;
    assign ocw2_cmd = wdata[7:5];
    assign ocw2_lvl = wdata[2:0];

    // A spurious acknowledge neither sets ISR nor clears IRR.
    assign ack_mask  = (ack1_go && pending) ? (8'b1 << winner) : 8'h00;
    assign aeoi_mask = (ack2_go && aeoi && !spurious_reg) ? (8'b1 << level_reg) : 8'h00;

    always_comb begin
        eoi_mask = 8'h00;
        if (ocw2_go) begin
            case (ocw2_cmd)
                3'b001, 3'b101: if (isr_found) eoi_mask = 8'b1 << isr_top;
                3'b011, 3'b111: eoi_mask = 8'b1 << ocw2_lvl;
                default:        eoi_mask = 8'h00;
            endcase
        end
    end

    // EOI clears first, then the acknowledge set, then the AEOI clear of
    // the level latched during the first pulse.
    assign isr_next = ((isr_reg & ~eoi_mask) | ack_mask) & ~aeoi_mask;

    // IRR per line: level mode follows ir; edge mode latches a rising edge
    // and drops when the line goes low. An acknowledge clear always wins.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_irr
            assign irr_next[gi] = ltim
                ? (ir[gi] & ~ack_mask[gi])
                : ((irr_reg[gi] | ~ir_q_reg[gi]) & ir[gi] & ~ack_mask[gi]);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irr_reg      <= 8'h00;
            isr_reg      <= 8'h00;
            imr_reg      <= 8'h00;
            ir_q_reg     <= 8'hFF;
            read_sel_reg <= 1'b0;
            state_reg    <= ST_IDLE;
            level_reg    <= 3'd0;
            spurious_reg <= 1'b0;
            int_req      <= 1'b0;
            vec_out      <= 8'h00;
            vec_valid    <= 1'b0;
        end else if (icw1_wr) begin
            // ir_q preset high so lines already asserted are not edges.
            irr_reg      <= 8'h00;
            isr_reg      <= 8'h00;
            imr_reg      <= 8'h00;
            ir_q_reg     <= 8'hFF;
            read_sel_reg <= 1'b0;
            state_reg    <= ST_IDLE;
            spurious_reg <= 1'b0;
            int_req      <= 1'b0;
            vec_valid    <= 1'b0;
        end else begin
            ir_q_reg  <= ir;
            irr_reg   <= irr_next;
            isr_reg   <= isr_next;
            int_req   <= pending && init_done;
            vec_valid <= ack2_go;
            if (init_done && ocw1_wr) imr_reg <= wdata;
            if (init_done && ocw3_wr && wdata[1]) read_sel_reg <= wdata[0];
            if (ack1_go) begin
                state_reg    <= ST_ACK1;
                level_reg    <= pending ? winner : 3'd7;
                spurious_reg <= !pending;
            end
            if (ack2_go) begin
                state_reg <= ST_IDLE;
                vec_out   <= {vec_base, level_reg};
            end
        end
    end

`ifdef PIC_ROTATE_EN
    logic [2:0] lowest_prio_reg, lowest_prio_next;
    logic       rot_aeoi_reg, rot_aeoi_next;

    assign lowest_prio = lowest_prio_reg;

    always_comb begin
        lowest_prio_next = lowest_prio_reg;
        rot_aeoi_next    = rot_aeoi_reg;
        if (ocw2_go) begin
            case (ocw2_cmd)
                3'b101:         if (isr_found) lowest_prio_next = isr_top;
                3'b111, 3'b110: lowest_prio_next = ocw2_lvl;
                3'b100:         rot_aeoi_next = 1'b1;
                3'b000:         rot_aeoi_next = 1'b0;
                default:        lowest_prio_next = lowest_prio_reg;
            endcase
        end
        // Automatic rotation follows the acknowledge, so it overrides an
        // OCW2 rotation landing in the same cycle.
        if ((aeoi_mask != 8'h00) && rot_aeoi_reg) lowest_prio_next = level_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lowest_prio_reg <= 3'd7;
            rot_aeoi_reg    <= 1'b0;
        end else if (icw1_wr) begin
            lowest_prio_reg <= 3'd7;
            rot_aeoi_reg    <= 1'b0;
        end else begin
            lowest_prio_reg <= lowest_prio_next;
            rot_aeoi_reg    <= rot_aeoi_next;
        end
    end
`else
    assign lowest_prio = 3'd7;
`endif

    assign rdata = a0 ? imr_reg : (read_sel_reg ? isr_reg : irr_reg);

endmodule

// File: tb/tb_pic_priority_core.sv
`timescale 1ns/1ps
module tb_pic_priority_core;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ir;
    logic       icw1_wr, init_done, ltim, aeoi;
    logic [4:0] vec_base;
    logic       ocw1_wr, ocw2_wr, ocw3_wr;
    logic [7:0] wdata;
    logic       inta, a0;
    logic       int_req;
    logic [7:0] vec_out;
    logic       vec_valid;
    logic [7:0] rdata;

    int passed = 0;
    int total  = 0;

    pic_priority_core dut (
        .clk(clk), .reset(reset), .ir(ir), .icw1_wr(icw1_wr),
        .init_done(init_done), .ltim(ltim), .aeoi(aeoi), .vec_base(vec_base),
        .ocw1_wr(ocw1_wr), .ocw2_wr(ocw2_wr), .ocw3_wr(ocw3_wr), .wdata(wdata),
        .inta(inta), .a0(a0), .int_req(int_req), .vec_out(vec_out),
        .vec_valid(vec_valid), .rdata(rdata)
    );

    always #5 clk = ~clk;

    // Stimulus helpers: inputs change and outputs are sampled 1 ns after
    // the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_inta();
        inta = 1'b1; tick(); inta = 1'b0;
    endtask

    task automatic pulse_icw1();
        icw1_wr = 1'b1; tick(); icw1_wr = 1'b0;
    endtask

    task automatic wr_ocw1(input logic [7:0] d);
        wdata = d; ocw1_wr = 1'b1; tick(); ocw1_wr = 1'b0;
    endtask

    task automatic wr_ocw2(input logic [7:0] d);
        wdata = d; ocw2_wr = 1'b1; tick(); ocw2_wr = 1'b0;
    endtask

    task automatic wr_ocw3(input logic [7:0] d);
        wdata = d; ocw3_wr = 1'b1; tick(); ocw3_wr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ir = 8'h00; icw1_wr = 1'b0; init_done = 1'b1; ltim = 1'b0;
        aeoi = 1'b0; vec_base = 5'b01000; ocw1_wr = 1'b0; ocw2_wr = 1'b0;
        ocw3_wr = 1'b0; wdata = 8'h00; inta = 1'b0; a0 = 1'b0;
        tick(); tick();
        total++; if (int_req !== 1'b0) $display("FAIL reset_int_req got=%0b exp=0", int_req); else passed++;
        total++; if (vec_valid !== 1'b0) $display("FAIL reset_vec_valid got=%0b exp=0", vec_valid); else passed++;
        total++; if (vec_out !== 8'h00) $display("FAIL reset_vec_out got=%h exp=00", vec_out); else passed++;
        total++; if (rdata !== 8'h00) $display("FAIL reset_irr got=%h exp=00", rdata); else passed++;
        a0 = 1'b1; #1;
        total++; if (rdata !== 8'h00) $display("FAIL reset_imr got=%h exp=00", rdata); else passed++;
        a0 = 1'b0;
        reset = 1'b0;
        tick(); tick();
    endtask

    task automatic test_basic_ack();
        ir = 8'h08;
        tick();
        total++; if (int_req !== 1'b0) $display("FAIL basic_latency0 got=%0b exp=0", int_req); else passed++;
        tick();
        total++; if (int_req !== 1'b1) $display("FAIL basic_int_req got=%0b exp=1", int_req); else passed++;
        pulse_inta();
        total++; if (vec_valid !== 1'b0) $display("FAIL basic_no_early_valid got=%0b exp=0", vec_valid); else passed++;
        pulse_inta();
        total++; if (vec_valid !== 1'b1) $display("FAIL basic_vec_valid got=%0b exp=1", vec_valid); else passed++;
        total++; if (vec_out !== 8'h43) $display("FAIL basic_vec_out got=%h exp=43", vec_out); else passed++;
        total++; if (int_req !== 1'b0) $display("FAIL basic_int_drop got=%0b exp=0", int_req); else passed++;
        tick();
        total++; if (vec_valid !== 1'b0) $display("FAIL basic_valid_pulse got=%0b exp=0", vec_valid); else passed++;
        wr_ocw3(8'h0B);
        total++; if (rdata !== 8'h08) $display("FAIL basic_isr got=%h exp=08", rdata); else passed++;
        wr_ocw3(8'h0A);
        total++; if (rdata !== 8'h00) $display("FAIL basic_irr got=%h exp=00", rdata); else passed++;
    endtask

    task automatic test_nested();
        ir = 8'h28;
        tick(); tick(); tick();
        total++; if (int_req !== 1'b0) $display("FAIL nested_lower_blocked got=%0b exp=0", int_req); else passed++;
        ir = 8'h2A;
        tick(); tick();
        total++; if (int_req !== 1'b1) $display("FAIL nested_higher_req got=%0b exp=1", int_req); else passed++;
        pulse_inta(); pulse_inta();
        total++; if (vec_out !== 8'h41) $display("FAIL nested_vec got=%h exp=41", vec_out); else passed++;
        wr_ocw3(8'h0B);
        total++; if (rdata !== 8'h0A) $display("FAIL nested_isr got=%h exp=0a", rdata); else passed++;
        total++; if (int_req !== 1'b0) $display("FAIL nested_int_after_ack got=%0b exp=0", int_req); else passed++;
        wr_ocw2(8'h20);
        total++; if (rdata !== 8'h08) $display("FAIL nested_eoi1 got=%h exp=08", rdata); else passed++;
        wr_ocw2(8'h20);
        total++; if (rdata !== 8'h00) $display("FAIL nested_eoi2 got=%h exp=00", rdata); else passed++;
        tick();
        total++; if (int_req !== 1'b1) $display("FAIL nested_ir5_unblocked got=%0b exp=1", int_req); else passed++;
        ir = 8'h00;
        tick(); tick();
        total++; if (int_req !== 1'b0) $display("FAIL nested_cleanup got=%0b exp=0", int_req); else passed++;
    endtask

    task automatic test_mask();
        wr_ocw1(8'h04);
        ir = 8'h04;
        tick(); tick(); tick();
        total++; if (int_req !== 1'b0) $display("FAIL mask_blocked got=%0b exp=0", int_req); else passed++;
        a0 = 1'b1; #1;
        total++; if (rdata !== 8'h04) $display("FAIL mask_imr_read got=%h exp=04", rdata); else passed++;
        a0 = 1'b0;
        wr_ocw1(8'h00);
        tick();
        total++; if (int_req !== 1'b1) $display("FAIL mask_unmasked got=%0b exp=1", int_req); else passed++;
        ir = 8'h00;
        tick(); tick();
    endtask

    task automatic test_rotate();
        logic [7:0] exp_vec;
`ifdef PIC_ROTATE_EN
        exp_vec = 8'h45;
`else
        exp_vec = 8'h43;
`endif
        wr_ocw2(8'hC4);
        ir = 8'h28;
        tick(); tick();
        total++; if (int_req !== 1'b1) $display("FAIL rotate_int_req got=%0b exp=1", int_req); else passed++;
        pulse_inta(); pulse_inta();
        total++; if (vec_out !== exp_vec) $display("FAIL rotate_vec got=%h exp=%h", vec_out, exp_vec); else passed++;
        ir = 8'h00;
        tick();
        wr_ocw2(8'h20);
        wr_ocw2(8'hC7);
        tick(); tick();
        total++; if (rdata !== 8'h00) $display("FAIL rotate_isr_clear got=%h exp=00", rdata); else passed++;
    endtask

    task automatic test_aeoi_spurious();
        aeoi = 1'b1;
        ir = 8'h40;
        tick(); tick();
        pulse_inta();
        total++; if (rdata !== 8'h40) $display("FAIL aeoi_isr_set got=%h exp=40", rdata); else passed++;
        pulse_inta();
        total++; if (vec_out !== 8'h46) $display("FAIL aeoi_vec got=%h exp=46", vec_out); else passed++;
        total++; if (rdata !== 8'h00) $display("FAIL aeoi_isr_clear got=%h exp=00", rdata); else passed++;
        ir = 8'h00; aeoi = 1'b0;
        tick();
        ir = 8'h10;
        tick(); tick();
        pulse_inta(); pulse_inta();
        ir = 8'h00;
        tick(); tick();
        pulse_inta(); pulse_inta();
        total++; if (vec_valid !== 1'b1) $display("FAIL spur_valid got=%0b exp=1", vec_valid); else passed++;
        total++; if (vec_out !== 8'h47) $display("FAIL spur_vec got=%h exp=47", vec_out); else passed++;
        total++; if (rdata !== 8'h10) $display("FAIL spur_isr_kept got=%h exp=10", rdata); else passed++;
        wr_ocw2(8'h64);
        total++; if (rdata !== 8'h00) $display("FAIL specific_eoi got=%h exp=00", rdata); else passed++;
    endtask

    task automatic test_icw1_mid_ack();
        wr_ocw1(8'h80);
        ir = 8'h04;
        tick(); tick();
        pulse_inta();
        pulse_icw1();
        total++; if (int_req !== 1'b0) $display("FAIL icw1_int_req got=%0b exp=0", int_req); else passed++;
        a0 = 1'b1; #1;
        total++; if (rdata !== 8'h00) $display("FAIL icw1_imr got=%h exp=00", rdata); else passed++;
        a0 = 1'b0;
        wr_ocw3(8'h0B);
        total++; if (rdata !== 8'h00) $display("FAIL icw1_isr got=%h exp=00", rdata); else passed++;
        pulse_inta();
        total++; if (vec_valid !== 1'b0) $display("FAIL icw1_no_vector got=%0b exp=0", vec_valid); else passed++;
        pulse_inta();
        ir = 8'h00;
        tick();
    endtask

    task automatic test_init_done();
        wr_ocw3(8'h0A);
        init_done = 1'b0;
        ir = 8'h01;
        tick(); tick(); tick();
        total++; if (int_req !== 1'b0) $display("FAIL initlow_int_req got=%0b exp=0", int_req); else passed++;
        total++; if (rdata !== 8'h01) $display("FAIL initlow_irr got=%h exp=01", rdata); else passed++;
        init_done = 1'b1;
        tick();
        total++; if (int_req !== 1'b1) $display("FAIL initdone_int_req got=%0b exp=1", int_req); else passed++;
        ir = 8'h00;
        tick(); tick();
    endtask

    task automatic test_level();
        ltim = 1'b1;
        ir = 8'h80;
        tick();
        total++; if (rdata !== 8'h80) $display("FAIL level_irr got=%h exp=80", rdata); else passed++;
        tick();
        total++; if (int_req !== 1'b1) $display("FAIL level_int_req got=%0b exp=1", int_req); else passed++;
        pulse_inta();
        total++; if (rdata !== 8'h00) $display("FAIL level_ack_clear got=%h exp=00", rdata); else passed++;
        tick();
        total++; if (rdata !== 8'h80) $display("FAIL level_refill got=%h exp=80", rdata); else passed++;
        pulse_inta();
        ir = 8'h00; ltim = 1'b0;
        tick();
        wr_ocw2(8'h20);
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_ack();
        test_nested();
        test_mask();
        test_rotate();
        test_aeoi_spurious();
        test_icw1_mid_ack();
        test_init_done();
        test_level();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
